// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the fetch front end.
// State encoding, PC-select codes and reset defaults.
package cpu_pipe_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_PC_STEP  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_REDIR = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select for the fetch unit.
// Hold, sequential increment, or word-aligned redirect.
module pc_next_mux
  import cpu_pipe_pkg::*;
#(
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic [1:0]  sel,
  input  logic [32:1] pc,
  input  logic [32:1] redir_addr,
  output logic [32:1] pc_inc,
  output logic [32:1] pc_next
);

  assign pc_inc = pc + 32'(PC_STEP);

  // Pick the PC that the next edge loads.
  always_comb begin
    pc_next = pc;
    unique case (sel)
      PC_INC:   pc_next = pc_inc;
      PC_REDIR: pc_next = align_pc(redir_addr);
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch stage with branch redirect and IF/ID output register.
// One bubble after each redirect; stall freezes everything.
module fetch_redirect_unit
  import cpu_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          PC_STEP  = DEF_PC_STEP
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall_in,
  input  logic        Redirect_in,
  input  logic [32:1] RedirectAddress_in,
  output logic        IMemReq_out,
  output logic [32:1] IMemAddr_out,
  input  logic        IMemReady_in,
  input  logic [32:1] IMemData_in,
  output logic [32:1] Instr_out,
  output logic [32:1] PC_out,
  output logic [32:1] NextPC_out,
  output logic        Valid_out,
  output logic        Flush_out
);

  fetch_state_e state_q, state_d;
  pc_sel_e      pc_sel;
  logic [32:1]  pc_q, pc_inc, pc_next;
  logic         load, valid_d, flush_d;

  pc_next_mux #(
    .PC_STEP (PC_STEP)
  ) u_mux (
    .sel        (pc_sel),
    .pc         (pc_q),
    .redir_addr (RedirectAddress_in),
    .pc_inc     (pc_inc),
    .pc_next    (pc_next)
  );

  assign IMemAddr_out = pc_q;

  // Next state, PC select and capture control.
  always_comb begin
    state_d     = state_q;
    pc_sel      = PC_HOLD;
    load        = 1'b0;
    valid_d     = Valid_out;
    flush_d     = 1'b0;
    IMemReq_out = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH, ST_WAIT: begin
        IMemReq_out = 1'b1;
        if (Redirect_in) begin
          pc_sel  = PC_REDIR;
          valid_d = 1'b0;
          flush_d = 1'b1;
          state_d = ST_REDIR;
        end else if (Stall_in) begin
          state_d = state_q;
        end else if (IMemReady_in) begin
          pc_sel  = PC_INC;
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = ST_FETCH;
        end else begin
          valid_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_REDIR: begin
        if (Redirect_in) begin
          pc_sel  = PC_REDIR;
          valid_d = 1'b0;
          flush_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC and IF/ID output registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      Instr_out  <= '0;
      PC_out     <= '0;
      NextPC_out <= '0;
      Valid_out  <= 1'b0;
      Flush_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_next;
      Valid_out <= valid_d;
      Flush_out <= flush_d;
      if (load) begin
        Instr_out  <= IMemData_in;
        PC_out     <= pc_q;
        NextPC_out <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit.
// Directed scenarios then random traffic against a flag model.
module tb_fetch_redirect_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Stall_in, Redirect_in, IMemReady_in;
  logic [31:0] RedirectAddress_in, IMemData_in;
  logic        IMemReq_out, Valid_out, Flush_out;
  logic [31:0] IMemAddr_out, Instr_out, PC_out, NextPC_out;

  int n_cmp = 0;
  int n_err = 0;

  // model: boot = first cycle out of reset, bubble = after redirect
  bit          m_boot, m_bubble, m_valid, m_flush;
  logic [31:0] m_pc, m_instr, m_pco, m_npc;

  always #5 CLK = ~CLK;

  fetch_redirect_unit dut (
    .CLK                (CLK),
    .Reset              (Reset),
    .Stall_in           (Stall_in),
    .Redirect_in        (Redirect_in),
    .RedirectAddress_in (RedirectAddress_in),
    .IMemReq_out        (IMemReq_out),
    .IMemAddr_out       (IMemAddr_out),
    .IMemReady_in       (IMemReady_in),
    .IMemData_in        (IMemData_in),
    .Instr_out          (Instr_out),
    .PC_out             (PC_out),
    .NextPC_out         (NextPC_out),
    .Valid_out          (Valid_out),
    .Flush_out          (Flush_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_bubble = 1'b0;
    m_valid  = 1'b0;
    m_flush  = 1'b0;
    m_pc     = 32'h0;
    m_instr  = 32'h0;
    m_pco    = 32'h0;
    m_npc    = 32'h0;
  endtask

  task automatic model_step(input bit s, input bit r,
                            input logic [31:0] a,
                            input bit rdy,
                            input logic [31:0] d);
    logic [31:0] tgt;
    tgt = a & 32'hFFFF_FFFC;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_bubble) begin
      if (r) begin
        m_pc    = tgt;
        m_flush = 1'b1;
      end else begin
        m_bubble = 1'b0;
        m_flush  = 1'b0;
      end
    end else if (r) begin
      m_pc     = tgt;
      m_valid  = 1'b0;
      m_flush  = 1'b1;
      m_bubble = 1'b1;
    end else if (!s) begin
      if (rdy) begin
        m_instr = d;
        m_pco   = m_pc;
        m_npc   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("req",   {31'd0, IMemReq_out},
                 {31'd0, !m_boot && !m_bubble});
    chk("addr",  IMemAddr_out, m_pc);
    chk("valid", {31'd0, Valid_out}, {31'd0, m_valid});
    chk("flush", {31'd0, Flush_out}, {31'd0, m_flush});
    chk("instr", Instr_out, m_instr);
    chk("pc",    PC_out, m_pco);
    chk("npc",   NextPC_out, m_npc);
  endtask

  // Drive one cycle from a negedge, step the model, check at next negedge.
  task automatic cyc(input bit s, input bit r,
                     input logic [31:0] a, input bit rdy);
    Stall_in           = s;
    Redirect_in        = r;
    RedirectAddress_in = a;
    IMemReady_in       = rdy;
    IMemData_in        = $urandom;
    @(posedge CLK);
    model_step(s, r, a, rdy, IMemData_in);
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    Reset = 1'b0;
    Stall_in = 1'b0;
    Redirect_in = 1'b0;
    RedirectAddress_in = '0;
    IMemReady_in = 1'b0;
    IMemData_in = '0;
    model_reset();
    @(negedge CLK);
    compare_all();
    Reset = 1'b1;

    // sequential fetch 0,4,8
    cyc(0, 0, 0, 1);
    chk("seq0", IMemAddr_out, 32'h0);
    chk("seq0_valid", {31'd0, Valid_out}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("seq4", IMemAddr_out, 32'h4);
    chk("seq4_valid", {31'd0, Valid_out}, 32'd1);
    cyc(0, 0, 0, 1);
    chk("seq8", IMemAddr_out, 32'h8);

    // memory not ready for 3 cycles at PC 8
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("wait_addr", IMemAddr_out, 32'h8);
    end
    cyc(0, 0, 0, 1);
    chk("wait_pc", PC_out, 32'h8);
    chk("wait_npc", NextPC_out, 32'hC);

    // redirect to 0x40 from PC 0x10
    for (int i = 0; i < 10 && IMemAddr_out != 32'h10; i++)
      cyc(0, 0, 0, 1);
    chk("reach10", IMemAddr_out, 32'h10);
    cyc(0, 1, 32'h40, 1);
    chk("rd_flush", {31'd0, Flush_out}, 32'd1);
    chk("rd_bubble", {31'd0, IMemReq_out}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("rd_flush_off", {31'd0, Flush_out}, 32'd0);
    chk("rd_target", IMemAddr_out, 32'h40);
    cyc(0, 0, 0, 1);
    chk("rd_cap", PC_out, 32'h40);

    // redirect beats stall; stall alone holds
    cyc(1, 1, 32'h80, 1);
    chk("rs_flush", {31'd0, Flush_out}, 32'd1);
    cyc(0, 0, 0, 1);
    chk("rs_target", IMemAddr_out, 32'h80);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
    chk("st_pc", PC_out, 32'h80);
    chk("st_addr", IMemAddr_out, 32'h84);

    // back-to-back redirects
    cyc(0, 1, 32'h100, 1);
    cyc(0, 1, 32'h200, 1);
    chk("bb_flush", {31'd0, Flush_out}, 32'd1);
    cyc(0, 0, 0, 1);
    chk("bb_target", IMemAddr_out, 32'h200);

    // async reset during WAIT
    cyc(0, 0, 0, 0);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    compare_all();
    Reset = 1'b1;
    cyc(0, 0, 0, 1);
    chk("rst_restart", IMemAddr_out, 32'h0);
    chk("rst_req", {31'd0, IMemReq_out}, 32'd1);

    // PC wrap and address alignment
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 1);
    chk("wr_addr", IMemAddr_out, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("wr_npc", NextPC_out, 32'h0);
    chk("wr_next", IMemAddr_out, 32'h0);
    cyc(0, 1, 32'h43, 1);
    cyc(0, 0, 0, 1);
    chk("align", IMemAddr_out, 32'h40);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 10) == 0,
          $urandom, ($urandom % 10) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
